// File: rtl/wb_pkg.sv
// Shared constants and state encoding for the weight-buffer loaders.
// Loader modules import this package to pick up default geometry and the FSM enum.
package wb_pkg;

  localparam int WB_AW  = 13;
  localparam int WB_DW  = 416;
  localparam int WB_IW  = 32;
  localparam int WB_LW  = 17;

  localparam int WB_WPL = WB_DW / WB_IW;
  localparam int WB_BW  = WB_DW / 8;
  localparam int WB_BPW = WB_IW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_be_gen.sv
// Fill-count to byte-enable thermometer: 'count_i' low slots of BPW bytes are enabled.
// Purely combinational so any buffer loader can reuse it.
module wb_be_gen
  import wb_pkg::*;
#(
  parameter int WPL = WB_WPL,
  parameter int BPW = WB_BPW,
  parameter int CW  = $clog2(WPL + 1)
) (
  input  logic [CW-1:0]        count_i,
  output logic [WPL*BPW-1:0]   be_o
);

  always_comb begin
    be_o = '0;
    for (int k = 0; k < WPL; k++) begin
      if (k < int'(count_i)) begin
        be_o[k*BPW +: BPW] = '1;
      end
    end
  end

endmodule

// File: rtl/wb_line_packer.sv
// Packs a stream of IW-bit weight words into DW-bit SRAM lines and drives the
// SRAM write port from a configured base line; a partial last line is masked by be.
//
// Handshake: a word transfers on a rising edge where s_valid and s_ready are both
// high; s_ready does not depend on s_valid, and s_valid may drop at any time.
module wb_line_packer
  import wb_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW,
  parameter int IW = WB_IW,
  parameter int LW = WB_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_base,
  input  logic [LW-1:0] cfg_words,
  input  logic          s_valid,
  input  logic [IW-1:0] s_data,
  output logic          s_ready,
  output logic          ena,
  output logic          wea,
  output logic [DW/8-1:0] be,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  output logic          busy,
  output logic          done
);

  localparam int WPL = DW / IW;
  localparam int BW  = DW / 8;
  localparam int BPW = IW / 8;
  localparam int WIW = $clog2(WPL);
  localparam int CW  = $clog2(WPL + 1);

  wb_state_e      state_q;
  logic [WIW-1:0] widx_q;
  logic [LW-1:0]  rem_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  line_q;

  logic           s_ready_q;
  logic           ena_q;
  logic           wea_q;
  logic [BW-1:0]  be_q;
  logic [AW-1:0]  addra_q;
  logic [DW-1:0]  dina_q;
  logic           busy_q;
  logic           done_q;

  logic [DW-1:0]  line_d;
  logic [CW-1:0]  fill_cnt_d;
  logic [BW-1:0]  be_d;
  logic           accept;
  logic           line_end;
  logic           last_word;

  // The line as it will look once the word on s_data lands in slot widx.
  always_comb begin
    line_d = line_q;
    line_d[int'(widx_q)*IW +: IW] = s_data;
  end

  assign fill_cnt_d = CW'(widx_q) + 1'b1;
  assign accept     = s_valid && s_ready_q;
  assign last_word  = (rem_q == LW'(1));
  assign line_end   = (widx_q == WIW'(WPL - 1)) || last_word;

  wb_be_gen #(
    .WPL (WPL),
    .BPW (BPW),
    .CW  (CW)
  ) u_be_gen (
    .count_i (fill_cnt_d),
    .be_o    (be_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      widx_q    <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      s_ready_q <= 1'b0;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      be_q      <= '0;
      addra_q   <= '0;
      dina_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ena_q  <= 1'b0;
      wea_q  <= 1'b0;
      be_q   <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            addr_q <= cfg_base;
            rem_q  <= cfg_words;
            widx_q <= '0;
            line_q <= '0;
            busy_q <= 1'b1;
            if (cfg_words == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q   <= ST_FILL;
              s_ready_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (accept) begin
            rem_q <= rem_q - 1'b1;
            if (line_end) begin
              ena_q   <= 1'b1;
              wea_q   <= 1'b1;
              be_q    <= be_d;
              dina_q  <= line_d;
              addra_q <= addr_q;
              addr_q  <= addr_q + 1'b1;
              line_q  <= '0;
              widx_q  <= '0;
            end else begin
              line_q <= line_d;
              widx_q <= widx_q + 1'b1;
            end
            if (last_word) begin
              s_ready_q <= 1'b0;
              state_q   <= ST_LAST;
            end
          end
        end
        ST_LAST: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Entered from LAST with done already high; an empty load arrives
          // here with done low and spends one extra cycle raising it.
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign ena     = ena_q;
  assign wea     = wea_q;
  assign be      = be_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_wb_line_packer.sv
// Directed bench for wb_line_packer: full, partial, empty, gapped, wrapping and
// reset-interrupted loads, with expected lines and cycles worked out in the bench.
module tb_wb_line_packer;

  localparam int AW = 13;
  localparam int DW = 416;
  localparam int IW = 32;
  localparam int LW = 17;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_words;
  logic          s_valid;
  logic [IW-1:0] s_data;
  logic          s_ready;
  logic          ena;
  logic          wea;
  logic [BW-1:0] be;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_mis = 0;

  // clock / reset
  always #5 clk = ~clk;

  wb_line_packer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_base  (cfg_base),
    .cfg_words (cfg_words),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ena       (ena),
    .wea       (wea),
    .be        (be),
    .addra     (addra),
    .dina      (dina),
    .busy      (busy),
    .done      (done)
  );

  // write log captured by the driver loop
  logic [AW-1:0] wa_q[$];
  logic [BW-1:0] wb_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];
  int cyc = 0;
  int start_cyc, acc_cyc, done_cyc, done_cnt, ready_low, ready_seen;

  localparam logic [BW-1:0] BE_ALL = {BW{1'b1}};

  function automatic logic [DW-1:0] exp_line(input int first, input int n,
                                            input logic [IW-1:0] dbase);
    logic [DW-1:0] l;
    l = '0;
    for (int k = 0; k < DW / IW; k++)
      if (k < n) l[k*IW +: IW] = dbase + IW'(first + k);
    return l;
  endfunction

  function automatic logic [BW-1:0] exp_be(input int n);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < DW / IW; k++)
      if (k < n) b[k*4 +: 4] = 4'hF;
    return b;
  endfunction

  // driver: one load, toggle=1 offers a word only every other cycle,
  // mid_at>=0 fires a stray cfg_start on that loop iteration
  task automatic run_load(input logic [AW-1:0] base, input logic [LW-1:0] words,
                          input bit toggle, input logic [IW-1:0] dbase,
                          input int mid_at, output bit timed_out);
    int idx;
    int post;
    bit seen_done;
    wa_q.delete(); wb_q.delete(); wd_q.delete(); wc_q.delete();
    done_cnt = 0; done_cyc = -1; acc_cyc = -1; ready_low = 0; ready_seen = 0;
    timed_out = 1'b1;
    idx = 0; post = 0; seen_done = 1'b0;
    @(negedge clk); cyc++;
    cfg_start = 1'b1; cfg_base = base; cfg_words = words;
    start_cyc = cyc;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); cyc++;
      cfg_start = 1'b0;
      if (ena) begin
        wa_q.push_back(addra); wb_q.push_back(be);
        wd_q.push_back(dina);  wc_q.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; seen_done = 1'b1; end
      if (s_ready) ready_seen++;
      if (idx < int'(words) && !s_ready) ready_low++;
      if (n == mid_at) begin
        cfg_start = 1'b1; cfg_base = 13'd3; cfg_words = 17'd2;
      end
      if (idx < int'(words) && (!toggle || (n % 2 == 0))) begin
        s_valid = 1'b1; s_data = dbase + IW'(idx);
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready) begin acc_cyc = cyc; idx++; end
      if (seen_done) begin
        post++;
        if (post > 3) begin timed_out = 1'b0; break; end
      end
    end
    s_valid = 1'b0; cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_words = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) begin @(negedge clk); cyc++; end
    n_vec++; if (s_ready !== 1'b0) begin n_mis++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_vec++; if (ena !== 1'b0)     begin n_mis++; $display("FAIL reset_ena: got %b want 0", ena); end
    n_vec++; if (wea !== 1'b0)     begin n_mis++; $display("FAIL reset_wea: got %b want 0", wea); end
    n_vec++; if (be !== '0)        begin n_mis++; $display("FAIL reset_be: got %h want 0", be); end
    n_vec++; if (addra !== '0)     begin n_mis++; $display("FAIL reset_addra: got %h want 0", addra); end
    n_vec++; if (dina !== '0)      begin n_mis++; $display("FAIL reset_dina: got %h want 0", dina); end
    n_vec++; if (busy !== 1'b0)    begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)    begin n_mis++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    @(negedge clk); cyc++;
  endtask

  task automatic test_full_line();
    bit to;
    run_load(13'd0, 17'd13, 1'b0, 32'h0, -1, to);
    n_vec++; if (to) begin n_mis++; $display("FAIL full_timeout: got no done want done"); end
    n_vec++; if (wa_q.size() != 1) begin n_mis++; $display("FAIL full_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() >= 1) begin
      n_vec++; if (wa_q[0] !== 13'd0) begin n_mis++; $display("FAIL full_addr: got %0d want 0", wa_q[0]); end
      n_vec++; if (wb_q[0] !== BE_ALL) begin n_mis++; $display("FAIL full_be: got %h want %h", wb_q[0], BE_ALL); end
      n_vec++; if (wd_q[0] !== exp_line(0, 13, 32'h0)) begin
        n_mis++; $display("FAIL full_data: got %h want %h", wd_q[0], exp_line(0, 13, 32'h0)); end
      n_vec++; if (wc_q[0] != start_cyc + 14) begin
        n_mis++; $display("FAIL full_wr_cycle: got %0d want %0d", wc_q[0] - start_cyc, 14); end
      n_vec++; if (wc_q[0] != acc_cyc + 1) begin
        n_mis++; $display("FAIL full_wr_latency: got %0d want 1", wc_q[0] - acc_cyc); end
      n_vec++; if (done_cyc != wc_q[0] + 1) begin
        n_mis++; $display("FAIL full_done_latency: got %0d want 1", done_cyc - wc_q[0]); end
    end
    n_vec++; if (done_cnt != 1) begin n_mis++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL full_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_partial();
    bit to;
    logic [DW-1:0] d;
    run_load(13'd5, 17'd27, 1'b0, 32'hA000_0000, -1, to);
    n_vec++; if (to) begin n_mis++; $display("FAIL part_timeout: got no done want done"); end
    n_vec++; if (wa_q.size() != 3) begin n_mis++; $display("FAIL part_nwrites: got %0d want 3", wa_q.size()); end
    if (wa_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (wa_q[i] !== AW'(5 + i)) begin
          n_mis++; $display("FAIL part_addr%0d: got %0d want %0d", i, wa_q[i], 5 + i); end
      end
      n_vec++; if (wb_q[0] !== BE_ALL || wb_q[1] !== BE_ALL) begin
        n_mis++; $display("FAIL part_be_full: got %h %h want %h", wb_q[0], wb_q[1], BE_ALL); end
      n_vec++; if (wb_q[2] !== 52'h0_0000_0000_000F) begin
        n_mis++; $display("FAIL part_be_last: got %h want f", wb_q[2]); end
      n_vec++; if (wd_q[1] !== exp_line(13, 13, 32'hA000_0000)) begin
        n_mis++; $display("FAIL part_data1: got %h want %h", wd_q[1], exp_line(13, 13, 32'hA000_0000)); end
      d = wd_q[2];
      n_vec++; if (d[31:0] !== 32'hA000_001A) begin
        n_mis++; $display("FAIL part_last_word: got %h want a000001a", d[31:0]); end
      n_vec++; if (d[DW-1:32] !== '0) begin
        n_mis++; $display("FAIL part_last_upper: got %h want 0", d[DW-1:32]); end
      n_vec++; if (done_cyc != wc_q[2] + 1) begin
        n_mis++; $display("FAIL part_done_latency: got %0d want 1", done_cyc - wc_q[2]); end
    end
    n_vec++; if (done_cnt != 1) begin n_mis++; $display("FAIL part_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_words();
    bit to;
    run_load(13'd9, 17'd0, 1'b0, 32'h0, -1, to);
    n_vec++; if (to) begin n_mis++; $display("FAIL zero_timeout: got no done want done"); end
    n_vec++; if (done_cyc != start_cyc + 2) begin
      n_mis++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc - start_cyc); end
    n_vec++; if (wa_q.size() != 0) begin n_mis++; $display("FAIL zero_writes: got %0d want 0", wa_q.size()); end
    n_vec++; if (ready_seen != 0) begin n_mis++; $display("FAIL zero_s_ready: got %0d high cycles want 0", ready_seen); end
    n_vec++; if (done_cnt != 1) begin n_mis++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_gaps();
    bit to;
    run_load(13'd40, 17'd26, 1'b1, 32'h0BAD_0000, -1, to);
    n_vec++; if (to) begin n_mis++; $display("FAIL gap_timeout: got no done want done"); end
    n_vec++; if (ready_low != 0) begin n_mis++; $display("FAIL gap_s_ready: got %0d low cycles want 0", ready_low); end
    n_vec++; if (wa_q.size() != 2) begin n_mis++; $display("FAIL gap_nwrites: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_vec++; if (wa_q[0] !== 13'd40 || wa_q[1] !== 13'd41) begin
        n_mis++; $display("FAIL gap_addr: got %0d %0d want 40 41", wa_q[0], wa_q[1]); end
      n_vec++; if (wd_q[0] !== exp_line(0, 13, 32'h0BAD_0000)) begin
        n_mis++; $display("FAIL gap_data0: got %h want %h", wd_q[0], exp_line(0, 13, 32'h0BAD_0000)); end
      n_vec++; if (wd_q[1] !== exp_line(13, 13, 32'h0BAD_0000)) begin
        n_mis++; $display("FAIL gap_data1: got %h want %h", wd_q[1], exp_line(13, 13, 32'h0BAD_0000)); end
      n_vec++; if (wb_q[1] !== exp_be(13)) begin
        n_mis++; $display("FAIL gap_be1: got %h want %h", wb_q[1], exp_be(13)); end
      n_vec++; if (done_cyc != wc_q[1] + 1) begin
        n_mis++; $display("FAIL gap_done_latency: got %0d want 1", done_cyc - wc_q[1]); end
    end
  endtask

  task automatic test_wrap_and_restart();
    bit to;
    run_load(13'd8191, 17'd26, 1'b0, 32'h5500_0000, 5, to);
    n_vec++; if (to) begin n_mis++; $display("FAIL wrap_timeout: got no done want done"); end
    n_vec++; if (wa_q.size() != 2) begin n_mis++; $display("FAIL wrap_nwrites: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_vec++; if (wa_q[0] !== 13'd8191) begin n_mis++; $display("FAIL wrap_addr0: got %0d want 8191", wa_q[0]); end
      n_vec++; if (wa_q[1] !== 13'd0) begin n_mis++; $display("FAIL wrap_addr1: got %0d want 0", wa_q[1]); end
      n_vec++; if (wd_q[1] !== exp_line(13, 13, 32'h5500_0000)) begin
        n_mis++; $display("FAIL wrap_data1: got %h want %h", wd_q[1], exp_line(13, 13, 32'h5500_0000)); end
    end
    n_vec++; if (done_cnt != 1) begin n_mis++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_load();
    bit to;
    int idx;
    wa_q.delete(); wb_q.delete(); wd_q.delete(); wc_q.delete();
    idx = 0; to = 1'b1;
    @(negedge clk); cyc++;
    cfg_start = 1'b1; cfg_base = 13'd2; cfg_words = 17'd13;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); cyc++;
      cfg_start = 1'b0;
      if (ena) wa_q.push_back(addra);
      if (idx == 7) begin to = 1'b0; break; end
      s_valid = 1'b1; s_data = 32'h100 + IW'(idx);
      if (s_ready) idx++;
    end
    n_vec++; if (to) begin n_mis++; $display("FAIL rmid_timeout: got %0d accepts want 7", idx); end
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk); cyc++;
    if (ena) wa_q.push_back(addra);
    n_vec++; if ({s_ready, ena, wea, busy, done} !== 5'b0) begin
      n_mis++; $display("FAIL rmid_ctrl: got %b want 00000", {s_ready, ena, wea, busy, done}); end
    n_vec++; if (be !== '0 || addra !== '0 || dina !== '0) begin
      n_mis++; $display("FAIL rmid_data: got be %h addra %h want 0", be, addra); end
    n_vec++; if (wa_q.size() != 0) begin n_mis++; $display("FAIL rmid_writes: got %0d want 0", wa_q.size()); end
    rst = 1'b0;
    run_load(13'd20, 17'd13, 1'b0, 32'h200, -1, to);
    n_vec++; if (to) begin n_mis++; $display("FAIL rmid_reload_timeout: got no done want done"); end
    n_vec++; if (wa_q.size() != 1) begin n_mis++; $display("FAIL rmid_reload_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      n_vec++; if (wa_q[0] !== 13'd20) begin n_mis++; $display("FAIL rmid_reload_addr: got %0d want 20", wa_q[0]); end
      n_vec++; if (wd_q[0] !== exp_line(0, 13, 32'h200)) begin
        n_mis++; $display("FAIL rmid_reload_data: got %h want %h", wd_q[0], exp_line(0, 13, 32'h200)); end
      n_vec++; if (wb_q[0] !== BE_ALL) begin n_mis++; $display("FAIL rmid_reload_be: got %h want %h", wb_q[0], BE_ALL); end
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_partial();
    test_zero_words();
    test_gaps();
    test_wrap_and_restart();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
